ce_divider_bank: RTL and testbench

//  Parametrised bank of NUM_CH independent clock-enable generators off clk_100mhz.

---
 rtl/ce_divider_pkg.sv | 15 +
 rtl/ce_channel.sv | 115 +++++++++++
 rtl/ce_divider_bank.sv | 50 +++++
 tb/tb_ce_divider_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ce_divider_pkg.sv
// Shared constants and helpers for the clock-enable divider bank.
//   CNT_W_DEF : default counter/divisor width
//   MAX_CH    : largest channel count addressable by the 4-bit cfg_ch field
//   eff_div() : maps a programmed divisor to the effective period (0 behaves as 1)
package ce_divider_pkg;

    localparam int CNT_W_DEF = 26;
    localparam int MAX_CH    = 16;
    localparam int DIV_FN_W  = 32;

    function automatic logic [DIV_FN_W-1:0] eff_div(input logic [DIV_FN_W-1:0] div);
        return (div == '0) ? DIV_FN_W'(1) : div;
    endfunction

endpackage

// File: rtl/ce_channel.sv
// One clock-enable channel: period counter, active + shadow divisor, pending flag,
// and an optional square-wave toggle flop (present only with CE_SQUARE_OUT_EN).
//   clk_100mhz, reset_n : clock, async active-low reset
//   en       : run enable; low holds the counter at 0 and applies any pending divisor
//   wr       : shadow-divisor write strobe (already decoded for this channel)
//   wr_div   : divisor value for wr
//   restart  : clear counter, apply pending divisor, suppress pulse this edge
//   ce       : registered one-cycle enable pulse
//   pending  : shadow divisor waiting to be applied
//   sq       : square wave toggling on each ce pulse (0 when feature disabled)
module ce_channel
    import ce_divider_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
    input  logic             clk_100mhz,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             restart,
    output logic             ce,
    output logic             pending,
    output logic             sq
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shd_q, div_shd_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic [CNT_W-1:0] d_eff;
    logic             tc;
    logic [CNT_W-1:0] shd_nxt;
    logic             pend_nxt;

    always_comb begin
        d_eff    = CNT_W'(eff_div(DIV_FN_W'(div_act_q)));
        tc       = (cnt_q == d_eff - CNT_W'(1));
        // A write this cycle is visible to an apply on the same edge.
        shd_nxt  = wr ? wr_div : div_shd_q;
        pend_nxt = wr | pend_q;

        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_shd_d = shd_nxt;
        pend_d    = pend_nxt;
        ce_d      = 1'b0;

        if (restart) begin
            // Restart applies what was pending before this cycle; a simultaneous
            // write lands in the shadow and stays pending.
            cnt_d = '0;
            if (pend_q) begin
                div_act_d = div_shd_q;
            end
            pend_d = wr;
        end else if (!en || tc) begin
            cnt_d = '0;
            ce_d  = en;
            if (pend_nxt) begin
                div_act_d = shd_nxt;
                pend_d    = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            div_act_q <= DIV_RST;
            div_shd_q <= DIV_RST;
            pend_q    <= 1'b0;
            ce_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            pend_q    <= pend_d;
            ce_q      <= ce_d;
        end
    end

    assign ce      = ce_q;
    assign pending = pend_q;

`ifdef CE_SQUARE_OUT_EN
    logic sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        if (restart || !en) begin
            sq_d = 1'b0;
        end else if (tc) begin
            sq_d = ~sq_q;
        end
    end

    always_ff @(posedge clk_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/ce_divider_bank.sv
// Bank of NUM_CH independent clock-enable generators with runtime divisors.
// Optional feature macro: CE_SQUARE_OUT_EN (enables sq_out square-wave outputs).
//   clk_100mhz, reset_n : clock, async active-low reset
//   ch_en        : per-channel run enable
//   cfg_we/cfg_ch/cfg_div : divisor write into channel shadow (cfg_ch >= NUM_CH ignored)
//   sync_restart : phase-align all channels, apply pending divisors
//   ce_out       : one-cycle enable pulses
//   cfg_pending  : per-channel shadow-not-yet-applied flags
//   sq_out       : 50% square waves (0 unless CE_SQUARE_OUT_EN)
module ce_divider_bank
    import ce_divider_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {26'd50000000, 26'd3333333, 26'd100}
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] sq_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;

        assign wr = cfg_we && (cfg_ch == 4'(i));

        ce_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_100mhz (clk_100mhz),
            .reset_n    (reset_n),
            .en         (ch_en[i]),
            .wr         (wr),
            .wr_div     (cfg_div),
            .restart    (sync_restart),
            .ce         (ce_out[i]),
            .pending    (cfg_pending[i]),
            .sq         (sq_out[i])
        );
    end

endmodule

// File: tb/tb_ce_divider_bank.sv
// Self-checking bench for ce_divider_bank: a cycle model predicts outputs per edge,
// expectations are queued when stimulus is applied and compared after the edge.
module tb_ce_divider_bank;

    localparam int NCH = 3;
    localparam int CW  = 26;
`ifdef CE_SQUARE_OUT_EN
    localparam logic SQ_EN = 1'b1;
`else
    localparam logic SQ_EN = 1'b0;
`endif

    logic           clk_100mhz = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] ch_en = 3'b111;
    logic           cfg_we = 1'b0;
    logic [3:0]     cfg_ch = 4'd0;
    logic [CW-1:0]  cfg_div = '0;
    logic           sync_restart = 1'b0;
    logic [NCH-1:0] ce_out, cfg_pending, sq_out;

    ce_divider_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV_INIT ({26'd1, 26'd3, 26'd4})
    ) dut (
        .clk_100mhz   (clk_100mhz),
        .reset_n      (reset_n),
        .ch_en        (ch_en),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .sync_restart (sync_restart),
        .ce_out       (ce_out),
        .cfg_pending  (cfg_pending),
        .sq_out       (sq_out)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct packed {
        logic [NCH-1:0] ce;
        logic [NCH-1:0] pend;
        logic [NCH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    int m_cnt[NCH], m_act[NCH], m_shd[NCH];
    bit m_pend[NCH], m_ce[NCH], m_sq[NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_act = '{4, 3, 1};
        m_shd = '{4, 3, 1};
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_pend[i] = 0; m_ce[i] = 0; m_sq[i] = 0;
        end
    endtask

    // Next-edge state of every channel given the inputs currently driven.
    task automatic model_edge();
        for (int i = 0; i < NCH; i++) begin
            int  d;
            bit  wr;
            d  = (m_act[i] == 0) ? 1 : m_act[i];
            wr = cfg_we && (int'(cfg_ch) == i);
            if (sync_restart) begin
                m_cnt[i] = 0; m_ce[i] = 0; m_sq[i] = 0;
                if (m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 0; end
                if (wr) begin m_shd[i] = int'(cfg_div); m_pend[i] = 1; end
            end else if (!ch_en[i]) begin
                m_cnt[i] = 0; m_ce[i] = 0; m_sq[i] = 0;
                if (wr) begin m_shd[i] = int'(cfg_div); m_act[i] = int'(cfg_div); end
                else if (m_pend[i]) m_act[i] = m_shd[i];
                m_pend[i] = 0;
            end else if (m_cnt[i] == d - 1) begin
                m_cnt[i] = 0; m_ce[i] = 1; m_sq[i] = !m_sq[i];
                if (wr) begin m_shd[i] = int'(cfg_div); m_act[i] = int'(cfg_div); end
                else if (m_pend[i]) m_act[i] = m_shd[i];
                m_pend[i] = 0;
            end else begin
                m_cnt[i]++; m_ce[i] = 0;
                if (wr) begin m_shd[i] = int'(cfg_div); m_pend[i] = 1; end
            end
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        for (int i = 0; i < NCH; i++) begin
            e.ce[i]   = m_ce[i];
            e.pend[i] = m_pend[i];
            e.sq[i]   = m_sq[i] & SQ_EN;
        end
        exp_q.push_back(e);
        @(posedge clk_100mhz);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("ce@%0d", cyc), 32'(ce_out), 32'(e.ce));
            chk($sformatf("pend@%0d", cyc), 32'(cfg_pending), 32'(e.pend));
            chk($sformatf("sq@%0d", cyc), 32'(sq_out), 32'(e.sq));
        end
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [CW-1:0] div);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = div;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_ce", 32'(ce_out), 32'd0);
        chk("rst_pend", 32'(cfg_pending), 32'd0);
        chk("rst_sq", 32'(sq_out), 32'd0);
        #11 reset_n = 1'b1;

        // Initial divisors {1,3,4}
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) chk("t1_ce2_e1", 32'(ce_out[2]), 32'd1);
            if (k == 3) chk("t1_ce1_e3", 32'(ce_out[1]), 32'd1);
            if (k == 4) chk("t1_ce0_e4", 32'(ce_out[0]), 32'd1);
            if (k == 6) chk("t1_ce1_e6", 32'(ce_out[1]), 32'd1);
            if (k == 7) chk("t1_ce0_e7", 32'(ce_out[0]), 32'd0);
            if (k == 8) chk("t1_ce0_e8", 32'(ce_out[0]), 32'd1);
        end

        // Mid-period write: ch0 cnt=1 when 6 is written
        step();
        cfg_write(4'd0, 26'd6);
        chk("t2_pend_set", 32'(cfg_pending[0]), 32'd1);
        for (int s = 2; s <= 9; s++) begin
            step();
            if (s == 3) begin
                chk("t2_ce0_old", 32'(ce_out[0]), 32'd1);
                chk("t2_pend_clr", 32'(cfg_pending[0]), 32'd0);
            end
            if (s == 6) chk("t2_ce0_gap", 32'(ce_out[0]), 32'd0);
            if (s == 9) chk("t2_ce0_new", 32'(ce_out[0]), 32'd1);
        end

        // Divisor 0 behaves as 1; out-of-range channel write ignored
        cfg_write(4'd1, 26'd0);
        for (int s = 0; s < 4; s++) step();
        for (int s = 0; s < 3; s++) begin
            step();
            chk("t3_ce1_hi", 32'(ce_out[1]), 32'd1);
        end
        cfg_write(4'd5, 26'd9);
        chk("t3_bad_ch", 32'(cfg_pending), 32'd0);

        // Restart with simultaneous write: write stays pending
        cfg_write(4'd1, 26'd3);
        sync_restart = 1'b1;
        cfg_write(4'd0, 26'd4);
        sync_restart = 1'b0;
        chk("t4_rs_ce", 32'(ce_out), 32'd0);
        chk("t4_rs_pend", 32'(cfg_pending), 32'd1);
        for (int s = 1; s <= 6; s++) begin
            step();
            if (s == 1) chk("t4_ce_s1", 32'(ce_out), 32'b100);
            if (s == 2) chk("t4_ce_s2", 32'(ce_out), 32'b100);
            if (s == 3) chk("t4_ce_s3", 32'(ce_out), 32'b110);
            if (s == 6) begin
                chk("t4_ce_s6", 32'(ce_out), 32'b111);
                chk("t4_pend_s6", 32'(cfg_pending), 32'd0);
            end
        end

        // ch0 disabled 7 cycles, then re-enabled with D=4
        ch_en = 3'b110;
        for (int s = 0; s < 7; s++) begin
            step();
            chk("t5_ce0_off", 32'(ce_out[0]), 32'd0);
        end
        ch_en = 3'b111;
        for (int s = 1; s <= 4; s++) begin
            step();
            chk($sformatf("t5_ce0_s%0d", s), 32'(ce_out[0]), (s == 4) ? 32'd1 : 32'd0);
        end

        // Square wave on ch1 (D=3), then asynchronous reset mid-run
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        chk("t6_sq_clr", 32'(sq_out), 32'd0);
        for (int s = 1; s <= 9; s++) begin
            step();
            if (s == 3) chk("t6_sq1_s3", 32'(sq_out[1]), 32'(SQ_EN));
            if (s == 6) chk("t6_sq1_s6", 32'(sq_out[1]), 32'd0);
            if (s == 9) chk("t6_sq1_s9", 32'(sq_out[1]), 32'(SQ_EN));
        end
        cfg_write(4'd0, 26'd7);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_arst_ce", 32'(ce_out), 32'd0);
        chk("t6_arst_pend", 32'(cfg_pending), 32'd0);
        chk("t6_arst_sq", 32'(sq_out), 32'd0);
        model_reset();
        #3 reset_n = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            step();
            if (s == 1) chk("t6_rel_s1", 32'(ce_out), 32'b100);
            if (s == 4) chk("t6_rel_ce0", 32'(ce_out[0]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
